// File: rtl/l2_mesi_cache_ctrl.sv
// L2 tag/MESI/LRU controller. It services L1 reads and writes and shared-bus
// snoops, and it issues writeback, read, RFO and invalidate operations on the
// shared bus. Only tags and coherence state are stored; there is no data payload.
module l2_mesi_cache_ctrl #(
  parameter int WAYS       = 8,
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 12,
  parameter int COUNT_W    = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [2:0]                     req_cmd,
  input  logic [TAG_BITS+INDEX_BITS-1:0] req_addr,
  output logic                           resp_valid,
  output logic                           resp_hit,
  output logic [1:0]                     resp_snoop,
  output logic                           bus_req_valid,
  output logic [1:0]                     bus_op,
  output logic [TAG_BITS+INDEX_BITS-1:0] bus_addr,
  input  logic                           bus_ack,
  input  logic                           bus_shared,
  output logic [COUNT_W-1:0]             hit_count,
  output logic [COUNT_W-1:0]             miss_count
);

  localparam int A     = TAG_BITS + INDEX_BITS;
  localparam int SETS  = 1 << INDEX_BITS;
  localparam int WAY_W = $clog2(WAYS);

  localparam logic [2:0] CMD_RD     = 3'd0;
  localparam logic [2:0] CMD_WR     = 3'd1;
  localparam logic [2:0] CMD_SNP_RD = 3'd2;
  localparam logic [2:0] CMD_SNP_RFO = 3'd3;
  localparam logic [2:0] CMD_SNP_INV = 3'd4;

  localparam logic [1:0] ST_I = 2'd0;
  localparam logic [1:0] ST_S = 2'd1;
  localparam logic [1:0] ST_E = 2'd2;
  localparam logic [1:0] ST_M = 2'd3;

  localparam logic [1:0] OP_READ = 2'd0;
  localparam logic [1:0] OP_RFO  = 2'd1;
  localparam logic [1:0] OP_WB   = 2'd2;
  localparam logic [1:0] OP_INV  = 2'd3;

  localparam logic [1:0] SNP_NOHIT = 2'd0;
  localparam logic [1:0] SNP_HIT   = 2'd1;
  localparam logic [1:0] SNP_HITM  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_FILL,
    S_UPG,
    S_RESP
  } state_t;

  state_t state;

  logic [TAG_BITS-1:0] tag_mem  [SETS][WAYS];
  logic [1:0]          mesi_mem [SETS][WAYS];
  logic [WAY_W-1:0]    age_mem  [SETS][WAYS];

  logic [2:0]          cmd_q;
  logic [A-1:0]        addr_q;
  logic [WAY_W-1:0]    way_q;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit;
  logic                  has_inv;
  logic [WAY_W-1:0]      hit_way;
  logic [WAY_W-1:0]      inv_way;
  logic [WAY_W-1:0]      lru_way;
  logic [WAY_W-1:0]      victim_way;
  logic [WAY_W-1:0]      touch_way;
  logic [1:0]            hit_state;
  logic [1:0]            victim_state;
  logic [TAG_BITS-1:0]   victim_tag;
  logic                  l1_cmd;
  logic                  bus_done;
  logic                  fill_done;
  logic                  touch_en;
  logic [WAY_W-1:0]      age_next [WAYS];

  // Saturating increment for the statistics counters.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign idx          = addr_q[INDEX_BITS-1:0];
  assign tag          = addr_q[A-1:INDEX_BITS];
  assign l1_cmd       = (cmd_q == CMD_RD) || (cmd_q == CMD_WR);
  assign victim_way   = has_inv ? inv_way : lru_way;
  assign hit_state    = mesi_mem[idx][hit_way];
  assign victim_state = mesi_mem[idx][victim_way];
  assign victim_tag   = tag_mem[idx][victim_way];
  // bus_ack only counts while a bus request is actually outstanding.
  assign bus_done     = bus_req_valid && bus_ack;
  assign fill_done    = (state == S_FILL) && bus_done;
  assign touch_way    = (state == S_FILL) ? way_q : hit_way;
  assign touch_en     = l1_cmd && (((state == S_LOOKUP) && hit) || fill_done);

  // Parallel tag compare; the lowest-index match, the lowest-index invalid
  // way and the oldest way are picked out in a single pass over the set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    lru_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (mesi_mem[idx][w] != ST_I && tag_mem[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (mesi_mem[idx][w] == ST_I) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
      if (age_mem[idx][w] == WAY_W'(WAYS - 1)) begin
        lru_way = WAY_W'(w);
      end
    end
  end

  // Age update for an access: the touched way becomes youngest and every
  // younger way ages by one, so the set keeps a permutation of ages.
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      age_next[w] = age_mem[idx][w];
      if (WAY_W'(w) == touch_way) begin
        age_next[w] = '0;
      end else if (age_mem[idx][w] < age_mem[idx][touch_way]) begin
        age_next[w] = age_mem[idx][w] + 1'b1;
      end
    end
  end

  // Tag install on fill completion; tags are only meaningful alongside a valid state.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_mem[idx][way_q] <= tag;
    end
  end

  // Controller FSM with registered outputs, MESI state and LRU ages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_hit      <= 1'b0;
      resp_snoop    <= SNP_NOHIT;
      bus_req_valid <= 1'b0;
      bus_op        <= 2'd0;
      bus_addr      <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
      cmd_q         <= '0;
      addr_q        <= '0;
      way_q         <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          mesi_mem[s][w] <= ST_I;
          age_mem[s][w]  <= WAY_W'(w);
        end
      end
    end else begin
      resp_valid <= 1'b0;

      if (touch_en) begin
        for (int w = 0; w < WAYS; w++) begin
          age_mem[idx][w] <= age_next[w];
        end
      end

      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            cmd_q     <= req_cmd;
            addr_q    <= req_addr;
            req_ready <= 1'b0;
            state     <= S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          resp_hit   <= hit;
          resp_snoop <= SNP_NOHIT;
          case (cmd_q)
            CMD_RD, CMD_WR: begin
              if (hit && cmd_q == CMD_WR && hit_state == ST_S) begin
                way_q    <= hit_way;
                bus_op   <= OP_INV;
                bus_addr <= addr_q;
                state    <= S_UPG;
              end else if (hit) begin
                if (cmd_q == CMD_WR) begin
                  mesi_mem[idx][hit_way] <= ST_M;
                end
                resp_valid <= 1'b1;
                state      <= S_RESP;
              end else begin
                way_q <= victim_way;
                if (victim_state == ST_M) begin
                  bus_op   <= OP_WB;
                  bus_addr <= {victim_tag, idx};
                  state    <= S_WB;
                end else begin
                  bus_op   <= (cmd_q == CMD_WR) ? OP_RFO : OP_READ;
                  bus_addr <= addr_q;
                  state    <= S_FILL;
                end
              end
            end

            CMD_SNP_RD, CMD_SNP_RFO: begin
              if (hit && hit_state == ST_M) begin
                way_q      <= hit_way;
                resp_snoop <= SNP_HITM;
                bus_op     <= OP_WB;
                bus_addr   <= addr_q;
                state      <= S_WB;
              end else begin
                if (hit) begin
                  resp_snoop             <= SNP_HIT;
                  mesi_mem[idx][hit_way] <= (cmd_q == CMD_SNP_RD) ? ST_S : ST_I;
                end
                resp_valid <= 1'b1;
                state      <= S_RESP;
              end
            end

            CMD_SNP_INV: begin
              if (hit) begin
                resp_snoop <= SNP_HIT;
                if (hit_state == ST_S) begin
                  mesi_mem[idx][hit_way] <= ST_I;
                end
              end
              resp_valid <= 1'b1;
              state      <= S_RESP;
            end

            default: begin
              resp_valid <= 1'b1;
              state      <= S_RESP;
            end
          endcase
        end

        S_WB: begin
          if (!bus_req_valid) begin
            bus_req_valid <= 1'b1;
          end else if (bus_done) begin
            bus_req_valid <= 1'b0;
            if (l1_cmd) begin
              bus_op   <= (cmd_q == CMD_WR) ? OP_RFO : OP_READ;
              bus_addr <= addr_q;
              state    <= S_FILL;
            end else begin
              mesi_mem[idx][way_q] <= (cmd_q == CMD_SNP_RD) ? ST_S : ST_I;
              resp_valid           <= 1'b1;
              state                <= S_RESP;
            end
          end
        end

        S_FILL: begin
          if (!bus_req_valid) begin
            bus_req_valid <= 1'b1;
          end else if (bus_done) begin
            bus_req_valid <= 1'b0;
            if (cmd_q == CMD_WR) begin
              mesi_mem[idx][way_q] <= ST_M;
            end else begin
              mesi_mem[idx][way_q] <= bus_shared ? ST_S : ST_E;
            end
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end
        end

        S_UPG: begin
          if (!bus_req_valid) begin
            bus_req_valid <= 1'b1;
          end else if (bus_done) begin
            bus_req_valid        <= 1'b0;
            mesi_mem[idx][way_q] <= ST_M;
            resp_valid           <= 1'b1;
            state                <= S_RESP;
          end
        end

        S_RESP: begin
          if (l1_cmd) begin
            if (resp_hit) begin
              hit_count <= sat_inc(hit_count);
            end else begin
              miss_count <= sat_inc(miss_count);
            end
          end
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end

        default: begin
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/l2_mesi_cache_ctrl.md
Name: l2_mesi_cache_ctrl

Overview:
- Parametrised, clocked successor to the combinational L2 tag/MESI store.
- N-way set-associative tag, MESI and age-LRU array; one request per transaction via valid/ready handshake.
- Services L1 reads/writes and shared-bus snoops, issuing writeback, read, RFO and invalidate on the shared bus.
- Sits between the trace-driven command source and the shared-bus/DRAM model. Data payload is not stored; tags and state only.

Parameters:
- WAYS, 8, associativity; power of two, ≥2.
- INDEX_BITS, 6, set index width; SETS = 2^INDEX_BITS.
- TAG_BITS, 12, tag width; line address width A = TAG_BITS+INDEX_BITS.
- COUNT_W, 16, width of the hit and miss statistics counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle, can accept a request.
- req_cmd  in  3  0 L1 read, 1 L1 write, 2 snoop read, 3 snoop RFO, 4 snoop invalidate; 5-7 reserved.
- req_addr  in  A  line address: {tag, index}.
- resp_valid  out  1  one-cycle completion pulse.
- resp_hit  out  1  valid line held when the lookup ran.
- resp_snoop  out  2  0 NOHIT, 1 HIT, 2 HITM; 0 for L1 commands.
- bus_req_valid  out  1  shared-bus operation pending.
- bus_op  out  2  0 READ, 1 RFO, 2 WRITEBACK, 3 INVALIDATE.
- bus_addr  out  A  line address of the bus operation.
- bus_ack  in  1  bus operation complete.
- bus_shared  in  1  sampled with bus_ack on READ: another cache holds the line.
- hit_count  out  COUNT_W  L1 hits; saturating.
- miss_count  out  COUNT_W  L1 misses; saturating.

Behaviour:
- Reset, asynchronous and effective immediately, even mid-transaction:
  - All lines go to I; way w age = w.
  - FSM goes to IDLE; req_ready=1; resp_valid=0, resp_hit=0, resp_snoop=0.
  - bus_req_valid=0, bus_op=0, bus_addr=0; both counters 0.
- FSM states: IDLE, LOOKUP, WB, FILL, UPG, RESP.
- IDLE: req_ready=1. Handshake on req_valid&&req_ready latches cmd/addr and moves to LOOKUP. req_ready=0 in every other state.
- LOOKUP: compares all ways in parallel. Hit means tag match and MESI≠I. Transitions:
  - L1 read hit → RESP.
  - L1 write hit: M/E → RESP, line becomes M. S → UPG.
  - L1 miss: victim in M → WB, else → FILL.
  - Snoop read:
    - M → WB, then S, HITM.
    - E → S, HIT.
    - S → unchanged, HIT.
    - I → NOHIT.
  - Snoop RFO:
    - M → WB, then I, HITM.
    - E or S → I, HIT.
  - Snoop invalidate: S → I, HIT. Any other state → no change, HIT if valid.
  - Reserved commands: → RESP, no state change, not counted.
- Victim selection: lowest-index invalid way; if none, the way with age WAYS-1.
- WB: bus_op=WRITEBACK, bus_addr = {victim tag, index} (snoop: req_addr). Held stable until bus_ack.
  - L1 miss → FILL. Snoop → RESP.
- FILL: L1 read issues READ; L1 write issues RFO. On bus_ack:
  - Install tag in victim.
  - MESI: read with bus_shared=1 → S; read with bus_shared=0 → E; write → M.
  - → RESP.
- UPG: bus_op=INVALIDATE at req_addr. On bus_ack: S→M, → RESP.
- Bus rules:
  - bus_req_valid rises in the cycle after entering WB/FILL/UPG.
  - bus_ack is honoured only while bus_req_valid=1, else ignored.
  - bus_req_valid falls in the cycle after ack.
  - No timeout.
- RESP: resp_valid=1 for exactly one cycle → IDLE.
  - resp_hit reflects LOOKUP.
  - Counters increment at RESP for L1 commands only, saturating at 2^COUNT_W-1.
- Latency: hit completes with resp_valid two cycles after the accept edge; a miss adds bus wait time.
- LRU: applies to L1 accesses (hit or fill) only; snoops never touch ages.
  - On access, the accessed way's age → 0; ways with age below its old age increment by 1.
  - Ages always stay a permutation of 0..WAYS-1 per set.
- Back-to-back: a new request may be accepted in the IDLE cycle following RESP. Throughput is one transaction per three cycles minimum.

Test Plan:
- Reset mid-FILL (bus_req_valid=1): assert rst_n=0 → bus_req_valid=0, req_ready=1 at once; a re-read of the same address misses.
- L1 read 0x0040 cold, bus_ack with bus_shared=0 → READ issued, resp_hit=0, line E, miss_count=1; repeat read → resp_hit=1 at accept+2, hit_count=1.
- 9 reads, same index, distinct tags, WAYS=8 → 9th evicts tag of 1st access, no WRITEBACK since all E; re-read of tag 1 misses.
- L1 write to S line → INVALIDATE then M; snoop read same addr → WRITEBACK, resp_snoop=2, line S.
- Write miss into a full set whose LRU victim is M → WRITEBACK of victim address, then RFO, resp_hit=0, new line M.
- Snoop RFO on E line → resp_snoop=1, line I, counters unchanged; cmd 6 → resp_valid pulse, no state change.
